// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared encodings for the load/store unit: load types, FSM states and the
// misaligned-access exception causes.
package ysyx_24110006_lsu_pkg;

  typedef enum logic [2:0] {
    RT_LB  = 3'b000,
    RT_LH  = 3'b001,
    RT_LW  = 3'b010,
    RT_LBU = 3'b100,
    RT_LHU = 3'b101
  } read_t_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MCAUSE_LMIS = 4'd4;
  localparam logic [3:0] MCAUSE_SMIS = 4'd6;

  localparam logic [3:0] WMASK_HALF = 4'b0011;
  localparam logic [3:0] WMASK_WORD = 4'b1111;

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational lane steering: shifts store data/strobes into their byte lanes
// and pulls load data down from its lane with sign or zero extension.
module ysyx_24110006_lsu_align
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [3:0]        wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        read_t,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] req_wdata,
  output logic [3:0]        req_wstrb,
  output logic [DATA_W-1:0] load_data
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] rword;

  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    req_wdata = wdata << shamt;
    req_wstrb = wmask << addr_lo;
    rword     = rdata >> shamt;
    // Unknown load types fall through to the whole word.
    case (read_t)
      RT_LB:   load_data = {{(DATA_W-8){rword[7]}}, rword[7:0]};
      RT_LBU:  load_data = {{(DATA_W-8){1'b0}}, rword[7:0]};
      RT_LH:   load_data = {{(DATA_W-16){rword[15]}}, rword[15:0]};
      RT_LHU:  load_data = {{(DATA_W-16){1'b0}}, rword[15:0]};
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: turns one execute-stage bundle into a single-beat bus access
// and hands the writeback bundle on. Define LSU_MISALIGN_EN for misalign traps.
module ysyx_24110006_lsu
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [3:0]        i_mem_wmask,
  input  logic [2:0]        i_mem_read_t,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [DATA_W-1:0] i_result,
  input  logic [4:0]        i_reg_rd,
  input  logic              i_reg_wen,
  input  logic [31:0]       i_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [4:0]        o_reg_rd,
  output logic              o_reg_wen,
  output logic [31:0]       o_pc,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic              o_req_wen,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [DATA_W-1:0] o_req_wdata,
  output logic [3:0]        o_req_wstrb,
  input  logic              i_rsp_valid,
  output logic              o_rsp_ready,
  input  logic [DATA_W-1:0] i_rsp_rdata,
  input  logic              i_rsp_err,
  output logic              o_access_fault
`ifdef LSU_MISALIGN_EN
  ,
  output logic              o_exception,
  output logic [3:0]        o_mcause
`endif
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [2:0]        read_t_q, read_t_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_wen_q, reg_wen_d;
  logic [31:0]       pc_q, pc_d;
  logic              fault_q, fault_d;
`ifdef LSU_MISALIGN_EN
  logic              exc_q, exc_d;
  logic [3:0]        mcause_q, mcause_d;
  logic              misalign;
`endif

  logic              accept;
  logic [DATA_W-1:0] shifted_wdata;
  logic [3:0]        shifted_wstrb;
  logic [DATA_W-1:0] load_data;

  ysyx_24110006_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .addr_lo   (addr_q[1:0]),
    .wmask     (wmask_q),
    .wdata     (wdata_q),
    .read_t    (read_t_q),
    .rdata     (i_rsp_rdata),
    .req_wdata (shifted_wdata),
    .req_wstrb (shifted_wstrb),
    .load_data (load_data)
  );

  assign o_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
  assign accept  = i_valid && o_ready;

`ifdef LSU_MISALIGN_EN
  always_comb begin
    misalign = 1'b0;
    if (i_mem_ren) begin
      case (i_mem_read_t)
        RT_LH, RT_LHU: misalign = i_mem_addr[0];
        RT_LW:         misalign = (i_mem_addr[1:0] != 2'b00);
        default:       misalign = 1'b0;
      endcase
    end else if (i_mem_wen) begin
      case (i_mem_wmask)
        WMASK_HALF: misalign = i_mem_addr[0];
        WMASK_WORD: misalign = (i_mem_addr[1:0] != 2'b00);
        default:    misalign = 1'b0;
      endcase
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    read_t_d  = read_t_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    result_d  = result_q;
    rd_d      = rd_q;
    reg_wen_d = reg_wen_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
`ifdef LSU_MISALIGN_EN
    exc_d     = exc_q;
    mcause_d  = mcause_q;
`endif

    case (state_q)
      ST_REQ:  if (i_req_ready) state_d = ST_RESP;
      ST_RESP: begin
        if (i_rsp_valid) begin
          state_d = ST_DONE;
          fault_d = i_rsp_err;
          if (ren_q) result_d = load_data;
        end
      end
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default: ;
    endcase

    // A new bundle overrides the DONE->IDLE step so back-to-back issue works.
    if (accept) begin
      addr_d    = i_mem_addr;
      wdata_d   = i_mem_wdata;
      wmask_d   = i_mem_wmask;
      read_t_d  = i_mem_read_t;
      ren_d     = i_mem_ren;
      wen_d     = i_mem_wen;
      result_d  = i_result;
      rd_d      = i_reg_rd;
      reg_wen_d = i_reg_wen;
      pc_d      = i_pc;
      fault_d   = 1'b0;
      state_d   = (i_mem_ren || i_mem_wen) ? ST_REQ : ST_DONE;
`ifdef LSU_MISALIGN_EN
      exc_d     = 1'b0;
      mcause_d  = 4'd0;
      if (misalign) begin
        state_d   = ST_DONE;
        result_d  = DATA_W'(i_mem_addr);
        reg_wen_d = 1'b0;
        exc_d     = 1'b1;
        mcause_d  = i_mem_ren ? MCAUSE_LMIS : MCAUSE_SMIS;
      end
`endif
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      read_t_q  <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      reg_wen_q <= 1'b0;
      pc_q      <= '0;
      fault_q   <= 1'b0;
`ifdef LSU_MISALIGN_EN
      exc_q     <= 1'b0;
      mcause_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      read_t_q  <= read_t_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      reg_wen_q <= reg_wen_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
`ifdef LSU_MISALIGN_EN
      exc_q     <= exc_d;
      mcause_q  <= mcause_d;
`endif
    end
  end

  // A bundle flagged as both load and store is treated as a load.
  assign o_req_valid    = (state_q == ST_REQ);
  assign o_req_wen      = wen_q && !ren_q;
  assign o_req_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_req_wdata    = shifted_wdata;
  assign o_req_wstrb    = o_req_wen ? shifted_wstrb : 4'b0000;
  assign o_rsp_ready    = (state_q == ST_RESP);
  assign o_valid        = (state_q == ST_DONE);
  assign o_result       = result_q;
  assign o_reg_rd       = rd_q;
  assign o_reg_wen      = reg_wen_q;
  assign o_pc           = pc_q;
  assign o_access_fault = fault_q;
`ifdef LSU_MISALIGN_EN
  assign o_exception    = exc_q;
  assign o_mcause       = mcause_q;
`endif

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for the LSU: randomized bundles, a reference model of the
// load/store rules, a bus responder and a writeback monitor.
module tb_ysyx_24110006_lsu;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [3:0]  i_mem_wmask;
  logic [2:0]  i_mem_read_t;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] i_result;
  logic [4:0]  i_reg_rd;
  logic        i_reg_wen;
  logic [31:0] i_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_reg_rd;
  logic        o_reg_wen;
  logic [31:0] o_pc;
  logic        o_req_valid;
  logic        i_req_ready;
  logic        o_req_wen;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_wdata;
  logic [3:0]  o_req_wstrb;
  logic        i_rsp_valid;
  logic        o_rsp_ready;
  logic [31:0] i_rsp_rdata;
  logic        i_rsp_err;
  logic        o_access_fault;
`ifdef LSU_MISALIGN_EN
  logic        o_exception;
  logic [3:0]  o_mcause;
`endif

  ysyx_24110006_lsu dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_mem_ren      (i_mem_ren),
    .i_mem_wen      (i_mem_wen),
    .i_mem_wmask    (i_mem_wmask),
    .i_mem_read_t   (i_mem_read_t),
    .i_mem_addr     (i_mem_addr),
    .i_mem_wdata    (i_mem_wdata),
    .i_result       (i_result),
    .i_reg_rd       (i_reg_rd),
    .i_reg_wen      (i_reg_wen),
    .i_pc           (i_pc),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_reg_rd       (o_reg_rd),
    .o_reg_wen      (o_reg_wen),
    .o_pc           (o_pc),
    .o_req_valid    (o_req_valid),
    .i_req_ready    (i_req_ready),
    .o_req_wen      (o_req_wen),
    .o_req_addr     (o_req_addr),
    .o_req_wdata    (o_req_wdata),
    .o_req_wstrb    (o_req_wstrb),
    .i_rsp_valid    (i_rsp_valid),
    .o_rsp_ready    (o_rsp_ready),
    .i_rsp_rdata    (i_rsp_rdata),
    .i_rsp_err      (i_rsp_err),
`ifdef LSU_MISALIGN_EN
    .o_exception    (o_exception),
    .o_mcause       (o_mcause),
`endif
    .o_access_fault (o_access_fault)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [31:0] pc;
    logic        fault;
    logic        exc;
    logic [3:0]  mcause;
    int          accept_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          req_wait;
    int          rsp_wait;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit bus_en = 1'b1;
  bit wbu_en = 1'b1;
  int stall_cnt = 0;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pick the addressed byte/half out of the word and extend it.
  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] a,
                                          input logic [2:0] rt);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = word >> (8 * a);
    b = w[7:0];
    h = w[15:0];
    case (rt)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'd0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic bit refMisaligned(input int kind, input logic [1:0] a,
                                       input logic [2:0] rt, input logic [3:0] wmask);
`ifdef LSU_MISALIGN_EN
    int size;
    size = 1;
    if (kind == K_LOAD) begin
      if (rt == 3'b001 || rt == 3'b101) size = 2;
      else if (rt == 3'b010) size = 4;
    end else if (kind == K_STORE) begin
      if (wmask == 4'b0011) size = 2;
      else if (wmask == 4'b1111) size = 4;
    end
    return (kind != K_ALU) && ((int'(a) % size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] result, input logic [31:0] pc,
                               input logic [2:0] rt, input logic [3:0] wmask,
                               input logic [4:0] rd, input logic rwen,
                               input logic [31:0] rdata, input logic err,
                               input int req_wait, input int rsp_wait);
    exp_t        e;
    bus_t        b;
    int          budget;
    bit          mis;
    logic [7:0]  m8;
    i_valid      = 1'b1;
    i_mem_ren    = (kind == K_LOAD);
    i_mem_wen    = (kind == K_STORE);
    i_mem_wmask  = wmask;
    i_mem_read_t = rt;
    i_mem_addr   = addr;
    i_mem_wdata  = wdata;
    i_result     = result;
    i_reg_rd     = rd;
    i_reg_wen    = rwen;
    i_pc         = pc;
    budget = 0;
    #2;
    while (!o_ready && budget < 200) begin
      @(negedge i_clock);
      #2;
      budget++;
    end
    if (!o_ready) begin
      checkOutput("accept_timeout", 32'(o_ready), 32'd1);
      @(negedge i_clock);
      i_valid = 1'b0;
      return;
    end
    mis = refMisaligned(kind, addr[1:0], rt, wmask);
    e.rd         = rd;
    e.pc         = pc;
    e.accept_cyc = cyc + 1;
    e.exc        = mis;
    e.mcause     = (kind == K_LOAD) ? 4'd4 : 4'd6;
    if (kind == K_ALU || mis) begin
      e.lat     = 1;
      e.result  = mis ? addr : result;
      e.reg_wen = mis ? 1'b0 : rwen;
      e.fault   = 1'b0;
    end else begin
      e.lat     = 3 + req_wait + rsp_wait;
      e.result  = (kind == K_LOAD) ? refLoad(rdata, addr[1:0], rt) : result;
      e.reg_wen = rwen;
      e.fault   = err;
      m8        = {4'b0000, wmask} << addr[1:0];
      b.wen      = (kind == K_STORE);
      b.addr     = {addr[31:2], 2'b00};
      b.wdata    = wdata << (8 * addr[1:0]);
      b.wstrb    = (kind == K_STORE) ? m8[3:0] : 4'b0000;
      b.rdata    = rdata;
      b.err      = err;
      b.req_wait = req_wait;
      b.rsp_wait = rsp_wait;
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_o_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_o_req_valid", 32'(o_req_valid), 32'd0);
    checkOutput("rst_o_rsp_ready", 32'(o_rsp_ready), 32'd0);
    checkOutput("rst_o_access_fault", 32'(o_access_fault), 32'd0);
    checkOutput("rst_o_result", o_result, 32'd0);
    checkOutput("rst_o_pc", o_pc, 32'd0);
    checkOutput("rst_o_reg_rd", 32'(o_reg_rd), 32'd0);
    checkOutput("rst_o_reg_wen", 32'(o_reg_wen), 32'd0);
`ifdef LSU_MISALIGN_EN
    checkOutput("rst_o_exception", 32'(o_exception), 32'd0);
`endif
  endtask

  // Bus responder: checks each request against the model and answers it.
  initial begin
    bus_t        b;
    bit          got;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_wstrb;
    logic        snap_wen;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_rdata = '0;
    i_rsp_err   = 1'b0;
    forever begin
      @(negedge i_clock);
      #1;
      if (bus_en && o_req_valid) begin
        got = (bus_q.size() > 0);
        b = '{wen: 1'b0, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0, rdata: 32'd0,
              err: 1'b0, req_wait: 0, rsp_wait: 0};
        if (got) b = bus_q.pop_front();
        else checkOutput("unexpected_req", 32'(o_req_valid), 32'd0);
        if (got) begin
          checkOutput("req_wen", 32'(o_req_wen), 32'(b.wen));
          checkOutput("req_addr", o_req_addr, b.addr);
          checkOutput("req_wstrb", 32'(o_req_wstrb), 32'(b.wstrb));
          if (b.wen) checkOutput("req_wdata", o_req_wdata, b.wdata);
        end
        snap_addr = o_req_addr; snap_wdata = o_req_wdata;
        snap_wstrb = o_req_wstrb; snap_wen = o_req_wen;
        for (int k = 0; k < b.req_wait; k++) begin
          @(negedge i_clock);
          #1;
          checkOutput("req_hold_valid", 32'(o_req_valid), 32'd1);
          checkOutput("req_hold_payload",
                      32'({snap_addr, snap_wdata, snap_wstrb, snap_wen} ==
                          {o_req_addr, o_req_wdata, o_req_wstrb, o_req_wen}), 32'd1);
        end
        i_req_ready = 1'b1;
        @(negedge i_clock);
        #1;
        i_req_ready = 1'b0;
        checkOutput("rsp_ready", 32'(o_rsp_ready), 32'd1);
        checkOutput("req_dropped", 32'(o_req_valid), 32'd0);
        for (int k = 0; k < b.rsp_wait; k++) begin
          @(negedge i_clock);
          #1;
        end
        i_rsp_valid = 1'b1;
        i_rsp_rdata = b.rdata;
        i_rsp_err   = b.err;
        @(negedge i_clock);
        #1;
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
        i_rsp_rdata = $urandom;
      end
    end
  end

  // Writeback monitor: pops the scoreboard on each handshake, checks stalls.
  initial begin
    exp_t        h;
    bit          timed;
    bit          stall_pending;
    logic [31:0] s_result, s_pc;
    logic [4:0]  s_rd;
    logic        s_wen, s_fault;
    timed = 1'b0;
    stall_pending = 1'b0;
    i_ready = 1'b0;
    forever begin
      @(negedge i_clock);
      if (wbu_en) begin
        if (stall_cnt > 0) begin
          i_ready = 1'b0;
          stall_cnt--;
        end else begin
          i_ready = ($urandom_range(0, 99) < 65);
        end
      end
      #1;
      if (wbu_en) begin
        if (stall_pending) begin
          checkOutput("stall_valid", 32'(o_valid), 32'd1);
          checkOutput("stall_stable",
                      32'({s_result, s_pc, s_rd, s_wen, s_fault} ==
                          {o_result, o_pc, o_reg_rd, o_reg_wen, o_access_fault}), 32'd1);
        end
        stall_pending = 1'b0;
        if (o_valid) begin
          checkOutput("ready_in_done", 32'(o_ready), 32'(i_ready));
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", 32'(o_valid), 32'd0);
          end else begin
            h = exp_q[0];
            if (!timed) begin
              checkOutput("latency", 32'(cyc), 32'(h.accept_cyc + h.lat - 1));
              timed = 1'b1;
            end
            if (i_ready) begin
              void'(exp_q.pop_front());
              timed = 1'b0;
              checkOutput("wb_result", o_result, h.result);
              checkOutput("wb_rd", 32'(o_reg_rd), 32'(h.rd));
              checkOutput("wb_reg_wen", 32'(o_reg_wen), 32'(h.reg_wen));
              checkOutput("wb_pc", o_pc, h.pc);
              checkOutput("wb_access_fault", 32'(o_access_fault), 32'(h.fault));
`ifdef LSU_MISALIGN_EN
              checkOutput("wb_exception", 32'(o_exception), 32'(h.exc));
              if (h.exc) checkOutput("wb_mcause", 32'(o_mcause), 32'(h.mcause));
`endif
            end else begin
              stall_pending = 1'b1;
              s_result = o_result; s_pc = o_pc; s_rd = o_reg_rd;
              s_wen = o_reg_wen; s_fault = o_access_fault;
            end
          end
        end
      end
    end
  end

  initial begin
    int          kind, rw, qw, pick, drain;
    logic [2:0]  rts[6];
    logic [3:0]  masks[3];
    logic [31:0] addr;
    rts   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    masks = '{4'b0001, 4'b0011, 4'b1111};
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_mem_wmask = '0; i_mem_read_t = '0;
    i_mem_addr = '0; i_mem_wdata = '0; i_result = '0; i_reg_rd = '0;
    i_reg_wen = 1'b0; i_pc = '0;
    repeat (3) @(negedge i_clock);
    #1;
    checkResetState();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);

    $display("[TB] directed bundles");
    applyStimulus(K_STORE, 32'h8000_0004, 32'h1122_3344, 32'hDEAD_0001, 32'h8000_0100,
                  3'b010, 4'b1111, 5'd0, 1'b0, 32'h0, 1'b0, 0, 0);
    applyStimulus(K_STORE, 32'h8000_0003, 32'h0000_00AB, 32'hDEAD_0002, 32'h8000_0104,
                  3'b000, 4'b0001, 5'd0, 1'b0, 32'h0, 1'b0, 0, 0);
    applyStimulus(K_LOAD, 32'h8000_0002, 32'h0, 32'h0, 32'h8000_0108,
                  3'b000, 4'b0001, 5'd5, 1'b1, 32'h00F0_0000, 1'b0, 0, 0);
    applyStimulus(K_LOAD, 32'h8000_0002, 32'h0, 32'h0, 32'h8000_010C,
                  3'b100, 4'b0001, 5'd6, 1'b1, 32'h00F0_0000, 1'b0, 0, 0);
    applyStimulus(K_LOAD, 32'h8000_0002, 32'h0, 32'h0, 32'h8000_0110,
                  3'b101, 4'b0011, 5'd7, 1'b1, 32'h8001_0000, 1'b0, 1, 2);
    stall_cnt = 5;
    applyStimulus(K_ALU, 32'h0, 32'h0, 32'h0000_0005, 32'h8000_0114,
                  3'b000, 4'b0000, 5'd3, 1'b1, 32'h0, 1'b0, 0, 0);
    applyStimulus(K_ALU, 32'h0, 32'h0, 32'h0000_0009, 32'h8000_0118,
                  3'b000, 4'b0000, 5'd4, 1'b1, 32'h0, 1'b0, 0, 0);
    applyStimulus(K_LOAD, 32'h8000_0040, 32'h0, 32'h0, 32'h8000_011C,
                  3'b010, 4'b1111, 5'd8, 1'b1, 32'hCAFE_BABE, 1'b1, 3, 0);
    applyStimulus(K_ALU, 32'h0, 32'h0, 32'h0000_0077, 32'h8000_0120,
                  3'b000, 4'b0000, 5'd9, 1'b1, 32'h0, 1'b0, 0, 0);
    applyStimulus(K_LOAD, 32'h8000_0001, 32'h0, 32'h0, 32'h8000_0124,
                  3'b010, 4'b1111, 5'd10, 1'b1, 32'h1234_5678, 1'b0, 0, 0);

    $display("[TB] random bundles");
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      pick = $urandom_range(0, 5);
      rw   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      qw   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(kind, addr, $urandom, $urandom, $urandom, rts[pick],
                    masks[$urandom_range(0, 2)], 5'($urandom), 1'($urandom),
                    $urandom, ($urandom_range(0, 7) == 0), rw, qw);
      repeat ($urandom_range(0, 2)) @(negedge i_clock);
    end

    drain = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && drain < 300) begin
      @(negedge i_clock);
      drain++;
    end
    checkOutput("drain_exp", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_bus", 32'(bus_q.size()), 32'd0);

    $display("[TB] reset during response phase");
    repeat (3) @(negedge i_clock);
    bus_en = 1'b0;
    wbu_en = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clock);
    i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_wen = 1'b0; i_mem_read_t = 3'b010;
    i_mem_addr = 32'h8000_0020; i_result = 32'h5555_5555; i_reg_rd = 5'd11;
    i_reg_wen = 1'b1; i_pc = 32'h8000_0200; i_mem_wmask = 4'b1111;
    @(negedge i_clock);
    i_valid = 1'b0;
    i_req_ready = 1'b1;
    @(negedge i_clock);
    i_req_ready = 1'b0;
    #1;
    checkOutput("mid_rsp_ready", 32'(o_rsp_ready), 32'd1);
    i_reset = 1'b0;
    #1;
    checkResetState();
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
